cnn_conv_engine: RTL and testbench
==================================

CNN_CONV_ENGINE -- requirements
Module: cnn_conv_engine

Interface
REQ-001 SHALL have parameter KERNEL_COUNT, default 4: number of kernels applied per run.
REQ-002 SHALL have parameter IMG_DIM, default 16: square input image side.
REQ-003 SHALL have parameter KER_DIM, default 4: square kernel side.
REQ-004 SHALL have parameter DATA_W, default 8: signed pixel, weight and output width.
REQ-005 SHALL have parameter ADDR_W, default 10: width of every memory address port.
REQ-006 SHALL have parameter FRAC, default 0: arithmetic right shift applied to each accumulator before clamping.
REQ-007 SHALL have port clk, input, 1: the single clock, rising-edge.
REQ-008 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1: run request, sampled only in IDLE.
REQ-010 SHALL have ports img_base, ker_base and out_base, input, ADDR_W each: base addresses of the image, kernel and output regions.
REQ-011 SHALL have ports stride2, input, 1 (1 = stride 2, 0 = stride 1) and relu_en, input, 1: ReLU enable.
REQ-012 SHALL have ports rd_en, output, 1 and rd_addr, output, ADDR_W: memory read request.
REQ-013 SHALL have port rd_data, input, DATA_W: read data, valid exactly 1 cycle after rd_en.
REQ-014 SHALL have ports wr_en, output, 1; wr_addr, output, ADDR_W; wr_data, output, DATA_W: result write.
REQ-015 SHALL have ports busy, output, 1 and done, output, 1.

Function
REQ-016 SHALL latch img_base, ker_base, out_base, stride2 and relu_en at the start-accept edge; later changes to them SHALL have no effect on the run.
REQ-017 SHALL have output side OD = (IMG_DIM-KER_DIM)/S + 1, where S = 2 if stride2 else 1; defaults give OD = 13 at S=1 and OD = 7 at S=2.
REQ-018 SHALL use these address maps: pixel (r,c) at img_base+r*IMG_DIM+c; weight k(i,j) at ker_base+k*KER_DIM^2+i*KER_DIM+j; output k(r,c) at out_base+k*OD^2+r*OD+c.
REQ-019 SHALL implement FSM states IDLE, LOAD_KER, MAC, WRITE, DONE.
REQ-020 IDLE SHALL move to LOAD_KER on the edge that samples start=1; busy SHALL be 1 in every state except IDLE.
REQ-021 LOAD_KER SHALL last KER_DIM^2+1 cycles: one read per cycle for KER_DIM^2 cycles, then one drain cycle, with the weights captured into internal registers.
REQ-022 MAC SHALL last KER_DIM^2+1 cycles per output pixel: window reads in row-major order, one multiply-accumulate per returned word.
REQ-023 WRITE SHALL last 1 cycle with wr_en=1, then go to MAC (next pixel), LOAD_KER (next kernel) or DONE (after the last kernel).
REQ-024 Output pixels SHALL be produced in row-major order within each kernel, and kernels in ascending index order.
REQ-025 DONE SHALL assert done for exactly 1 cycle, then return to IDLE.
REQ-026 Accumulator width SHALL be 2*DATA_W+$clog2(KER_DIM^2), signed, with no internal overflow.
REQ-027 Result processing SHALL be: arithmetic shift right by FRAC; if relu_en, negative values become 0; then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-028 done SHALL assert KERNEL_COUNT*((KER_DIM^2+1)+OD^2*(KER_DIM^2+2))+1 cycles after the start-accept edge.
REQ-029 start while busy SHALL be ignored.
REQ-030 rd_en and wr_en SHALL never be 1 in the same cycle.

Reset
REQ-031 rst=1 SHALL, at the next edge, force IDLE and drive busy, done, rd_en and wr_en to 0 and rd_addr, wr_addr and wr_data to 0.
REQ-032 rst SHALL take priority over start when both are 1 at the same edge.
REQ-033 rst mid-run SHALL abort the run with no further writes; a new start after reset SHALL run normally.

Verification
REQ-034 Image all 1, kernels all 1, S=1, defaults -> 676 writes, all wr_data=16, last wr_addr=out_base+675, done 12237 cycles after start.
REQ-035 Image all 127, kernels all 127 -> every wr_data=127 (saturated from 258064).
REQ-036 Image all 1, kernels all -1 -> relu_en=0: wr_data=8'hF0 (-16); relu_en=1: wr_data=0.
REQ-037 stride2=1 -> 49 writes per kernel, last wr_addr=out_base+195, done 3597 cycles after start.
REQ-038 rst pulsed 500 cycles into a run -> busy=0 and wr_en=0 from the next edge, done never asserts; a restart then matches REQ-034.
REQ-039 start re-pulsed mid-run -> no effect on the write sequence or on done timing.

Source files
------------

// File: rtl/cnn_conv_engine.sv
// Convolution engine: streams kernels and image windows from memory, multiply-accumulates
// each window, post-processes (shift, optional ReLU, saturate) and writes one result per pixel.
module cnn_conv_engine #(
    parameter int unsigned KERNEL_COUNT = 4,
    parameter int unsigned IMG_DIM      = 16,
    parameter int unsigned KER_DIM      = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned FRAC         = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] ker_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic              stride2,
    input  logic              relu_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned KK    = KER_DIM * KER_DIM;
    localparam int unsigned CNT_W = $clog2(KK + 1);
    localparam int unsigned IDX_W = (KK > 1) ? $clog2(KK) : 1;
    localparam int unsigned ACC_W = 2 * DATA_W + $clog2(KK);
    localparam int unsigned PRD_W = 2 * DATA_W;
    localparam int unsigned OD1   = IMG_DIM - KER_DIM + 1;
    localparam int unsigned OD2   = (IMG_DIM - KER_DIM) / 2 + 1;
    localparam int unsigned OD_W  = $clog2(OD1 + 1);
    localparam int unsigned K_W   = (KERNEL_COUNT > 1) ? $clog2(KERNEL_COUNT) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KER,
        MAC,
        WRITE,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [OD_W-1:0]            orow_q, orow_d, ocol_q, ocol_d;
    logic [K_W-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [ADDR_W-1:0]          img_base_q, img_base_d, ker_base_q, ker_base_d;
    logic                       stride_q, stride_d, relu_q, relu_d;
    logic [ADDR_W-1:0]          wptr_q, wptr_d;
    logic signed [DATA_W-1:0]   w_q [KK];
    logic signed [DATA_W-1:0]   w_d [KK];

    logic                       rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic                       busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]          wr_data_q, wr_data_d;

    logic [IDX_W-1:0]           widx_c;
    logic signed [PRD_W-1:0]    prod_c;
    logic signed [ACC_W-1:0]    acc_base_c, sh_c;
    logic [OD_W-1:0]            od_c;
    int unsigned                sm_c, ki_c, kj_c, row_c, col_c;

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

    // Sequencing: cnt is the cycle index inside LOAD_KER/MAC; data for read n lands at cnt n+1.
    always_comb begin : fsm_comb
        state_d    = state_q;
        cnt_d      = cnt_q;
        orow_d     = orow_q;
        ocol_d     = ocol_q;
        k_d        = k_q;
        acc_d      = acc_q;
        img_base_d = img_base_q;
        ker_base_d = ker_base_q;
        stride_d   = stride_q;
        relu_d     = relu_q;
        wptr_d     = wptr_q;
        w_d        = w_q;
        widx_c     = IDX_W'(cnt_q - CNT_W'(1));
        prod_c     = PRD_W'($signed(rd_data)) * PRD_W'(w_q[widx_c]);
        acc_base_c = (cnt_q == CNT_W'(1)) ? '0 : acc_q;
        od_c       = stride_q ? OD_W'(OD2) : OD_W'(OD1);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD_KER;
                    cnt_d      = '0;
                    orow_d     = '0;
                    ocol_d     = '0;
                    k_d        = '0;
                    img_base_d = img_base;
                    ker_base_d = ker_base;
                    stride_d   = stride2;
                    relu_d     = relu_en;
                    wptr_d     = out_base;
                end
            end
            LOAD_KER: begin
                if (cnt_q != '0) w_d[widx_c] = $signed(rd_data);
                if (cnt_q == CNT_W'(KK)) begin
                    state_d = MAC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MAC: begin
                if (cnt_q != '0) acc_d = acc_base_c + ACC_W'(prod_c);
                if (cnt_q == CNT_W'(KK)) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE: begin
                wptr_d  = wptr_q + ADDR_W'(1);
                cnt_d   = '0;
                state_d = MAC;
                if (ocol_q == od_c - OD_W'(1)) begin
                    ocol_d = '0;
                    if (orow_q == od_c - OD_W'(1)) begin
                        orow_d = '0;
                        if (k_q == K_W'(KERNEL_COUNT - 1)) begin
                            state_d = DONE;
                        end else begin
                            k_d     = k_q + K_W'(1);
                            state_d = LOAD_KER;
                        end
                    end else begin
                        orow_d = orow_q + OD_W'(1);
                    end
                end else begin
                    ocol_d = ocol_q + OD_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs for the coming cycle, derived from the next-state values.
    always_comb begin : out_comb
        sm_c  = stride_d ? 32'd2 : 32'd1;
        ki_c  = 32'(cnt_d) / KER_DIM;
        kj_c  = 32'(cnt_d) % KER_DIM;
        row_c = 32'(orow_d) * sm_c + ki_c;
        col_c = 32'(ocol_d) * sm_c + kj_c;

        sh_c = acc_d >>> FRAC;
        if (relu_q && sh_c[ACC_W-1]) sh_c = '0;
        if (sh_c > SAT_MAX)      sh_c = SAT_MAX;
        else if (sh_c < SAT_MIN) sh_c = SAT_MIN;

        busy_d    = (state_d != IDLE);
        rd_en_d   = ((state_d == LOAD_KER) || (state_d == MAC)) && (cnt_d < CNT_W'(KK));
        rd_addr_d = '0;
        if (rd_en_d) begin
            if (state_d == LOAD_KER)
                rd_addr_d = ker_base_d + ADDR_W'(32'(k_d) * KK + 32'(cnt_d));
            else
                rd_addr_d = img_base_d + ADDR_W'(row_c * IMG_DIM + col_c);
        end
        wr_en_d   = (state_d == WRITE);
        wr_addr_d = wr_en_d ? wptr_q : '0;
        wr_data_d = wr_en_d ? DATA_W'(sh_c) : '0;
        done_d    = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            orow_q     <= '0;
            ocol_q     <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            img_base_q <= '0;
            ker_base_q <= '0;
            stride_q   <= 1'b0;
            relu_q     <= 1'b0;
            wptr_q     <= '0;
            w_q        <= '{default: '0};
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            img_base_q <= img_base_d;
            ker_base_q <= ker_base_d;
            stride_q   <= stride_d;
            relu_q     <= relu_d;
            wptr_q     <= wptr_d;
            w_q        <= w_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Bench for cnn_conv_engine: table of directed runs, random runs against a plain convolution
// model, plus reset-abort, reset/start collision and mid-run disturbance sequences.
module tb_cnn_conv_engine;

    localparam int KC  = 4;
    localparam int IMG = 16;
    localparam int KD  = 4;
    localparam int KK  = KD * KD;
    localparam int FR  = 0;
    localparam int IB  = 0;
    localparam int KB  = 256;
    localparam int OB  = 320;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] img_base = 10'(IB);
    logic [9:0] ker_base = 10'(KB);
    logic [9:0] out_base = 10'(OB);
    logic       stride2 = 1'b0;
    logic       relu_en = 1'b0;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic [7:0] rd_data = 8'd0;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;

    cnn_conv_engine dut (
        .clk(clk), .rst(rst), .start(start),
        .img_base(img_base), .ker_base(ker_base), .out_base(out_base),
        .stride2(stride2), .relu_en(relu_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic signed [7:0] mem [0:1023];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int vectors = 0;
    int miscompares = 0;
    int exp_addr[$];
    int exp_data[$];

    typedef struct {
        int img_v;
        int ker_v;
        bit s2;
        bit relu;
        int exp_val;
        int exp_writes;
        int exp_last;
        int exp_lat;
        bit disturb;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int od_of(input bit s2);
        return (IMG - KD) / (s2 ? 2 : 1) + 1;
    endfunction

    function automatic int lat_of(input bit s2);
        int od;
        od = od_of(s2);
        return KC * ((KK + 1) + od * od * (KK + 2)) + 1;
    endfunction

    task automatic fill(input int iv, input int kv, input bit rnd);
        for (int a = 0; a < 1024; a++) mem[a] = 8'(a * 7 + 3);
        for (int a = 0; a < IMG * IMG; a++) mem[IB + a] = rnd ? 8'($urandom) : 8'(iv);
        for (int a = 0; a < KC * KK; a++)   mem[KB + a] = rnd ? 8'($urandom) : 8'(kv);
    endtask

    // Direct convolution over the memory image, one expected (addr, data) per output pixel.
    task automatic build_model(input bit s2, input bit relu);
        int s, od, acc;
        s  = s2 ? 2 : 1;
        od = od_of(s2);
        exp_addr.delete();
        exp_data.delete();
        for (int k = 0; k < KC; k++)
            for (int r = 0; r < od; r++)
                for (int c = 0; c < od; c++) begin
                    acc = 0;
                    for (int i = 0; i < KD; i++)
                        for (int j = 0; j < KD; j++)
                            acc += int'(mem[IB + (r * s + i) * IMG + c * s + j]) *
                                   int'(mem[KB + k * KK + i * KD + j]);
                    acc = acc >>> FR;
                    if (relu && acc < 0) acc = 0;
                    if (acc > 127)  acc = 127;
                    if (acc < -128) acc = -128;
                    exp_addr.push_back(OB + k * od * od + r * od + c);
                    exp_data.push_back(acc);
                end
    endtask

    task automatic run(input bit s2, input bit relu, input int const_val, input bit use_const,
                       input int abort_at, input bit disturb,
                       output int n_wr, output int last_addr, output int lat);
        int budget, seen;
        build_model(s2, relu);
        @(negedge clk);
        img_base = 10'(IB); ker_base = 10'(KB); out_base = 10'(OB);
        stride2 = s2; relu_en = relu; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_wr = 0; last_addr = -1; lat = -1;
        budget = lat_of(s2) + 50;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk); #1;
            if (wr_en) begin
                n_wr++;
                last_addr = int'(wr_addr);
                chk("rd_wr_overlap", longint'(rd_en), 0);
                if (exp_addr.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    chk("wr_addr", int'(wr_addr), exp_addr.pop_front());
                    chk("wr_data", int'($signed(wr_data)), exp_data.pop_front());
                end
                if (use_const) chk("wr_const", int'($signed(wr_data)), const_val);
            end
            if (done) begin
                lat = cyc;
                @(posedge clk); #1;
                chk("done_width", longint'(done), 0);
                chk("busy_after_done", longint'(busy), 0);
                break;
            end
            if (abort_at == cyc) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("abort_busy", longint'(busy), 0);
                chk("abort_wr_en", longint'(wr_en), 0);
                chk("abort_rd_en", longint'(rd_en), 0);
                seen = 0;
                repeat (300) begin
                    @(posedge clk); #1;
                    if (done || wr_en || busy) seen++;
                end
                chk("abort_quiet", seen, 0);
                lat = -2;
                break;
            end
            if (disturb) begin
                if (cyc == 3) begin
                    img_base = 10'd700; ker_base = 10'd600; out_base = 10'd5;
                    stride2 = ~s2; relu_en = ~relu;
                end
                start = ((cyc % 997) == 5);
            end
        end
        start = 1'b0;
        stride2 = s2; relu_en = relu;
        img_base = 10'(IB); ker_base = 10'(KB); out_base = 10'(OB);
        if (lat != -2) chk("writes_pending", exp_addr.size(), 0);
    endtask

    initial begin
        vec_t tbl[5];
        int n_wr, last_addr, lat, od;
        bit s2, relu;

        tbl[0] = '{1,   1,   1'b0, 1'b0, 16,  676, 675, 12237, 1'b0};
        tbl[1] = '{127, 127, 1'b1, 1'b0, 127, 196, 195, 3597,  1'b0};
        tbl[2] = '{1,   -1,  1'b1, 1'b0, -16, 196, 195, 3597,  1'b0};
        tbl[3] = '{1,   -1,  1'b1, 1'b1, 0,   196, 195, 3597,  1'b0};
        tbl[4] = '{1,   1,   1'b1, 1'b0, 16,  196, 195, 3597,  1'b1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_rd_en", longint'(rd_en), 0);
        chk("rst_wr_en", longint'(wr_en), 0);
        chk("rst_rd_addr", longint'(rd_addr), 0);
        chk("rst_wr_addr", longint'(wr_addr), 0);
        chk("rst_wr_data", longint'(wr_data), 0);
        rst = 1'b0;

        // Reset and start together: reset wins and the start is lost.
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        chk("rst_start_busy", longint'(busy), 0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("rst_start_idle", longint'(busy), 0);
        chk("rst_start_rd_en", longint'(rd_en), 0);

        for (int t = 0; t < 5; t++) begin
            fill(tbl[t].img_v, tbl[t].ker_v, 1'b0);
            run(tbl[t].s2, tbl[t].relu, tbl[t].exp_val, 1'b1, 0, tbl[t].disturb,
                n_wr, last_addr, lat);
            chk("tbl_writes", n_wr, tbl[t].exp_writes);
            chk("tbl_last_addr", last_addr - OB, tbl[t].exp_last);
            chk("tbl_done_latency", lat, tbl[t].exp_lat);
        end

        for (int r = 0; r < 3; r++) begin
            fill(0, 0, 1'b1);
            s2   = (r != 0);
            relu = 1'($urandom);
            od   = od_of(s2);
            run(s2, relu, 0, 1'b0, 0, 1'b0, n_wr, last_addr, lat);
            chk("rnd_writes", n_wr, KC * od * od);
            chk("rnd_done_latency", lat, lat_of(s2));
        end

        // Abort 500 cycles in, then a clean rerun of the all-ones case.
        fill(1, 1, 1'b0);
        run(1'b0, 1'b0, 16, 1'b1, 500, 1'b0, n_wr, last_addr, lat);
        chk("abort_no_done", lat, -2);
        run(1'b0, 1'b0, 16, 1'b1, 0, 1'b0, n_wr, last_addr, lat);
        chk("restart_writes", n_wr, 676);
        chk("restart_last_addr", last_addr - OB, 675);
        chk("restart_done_latency", lat, 12237);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
